// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped, one-word-per-block read-only instruction cache with a single-read miss channel.
// Optional hit/miss statistics counters are built only when ICACHE_STATS_EN is defined.
module icache_fetch_ctrl #(
    parameter int unsigned SETS   = 16,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    output logic [WORD_W-1:0] imemload,
    output logic              ihit,
    input  logic              flush,
    output logic              iREN,
    output logic [ADDR_W-1:0] iaddr,
    input  logic [WORD_W-1:0] iload,
    input  logic              iwait,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic {
        IDLE,
        FETCH
    } state_e;

    state_e state_q, state_d;

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [WORD_W-1:0] data_q [SETS];

    logic [ADDR_W-3:0] miss_addr_q;
    logic [ADDR_W-3:0] miss_addr_d;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              lookup_hit;
    logic              miss;
    logic              fill;

    logic unused_byte_offset;
    assign unused_byte_offset = ^imemaddr[1:0];

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[ADDR_W-1:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W-1:0];
    assign fill_tag = miss_addr_q[ADDR_W-3:IDX_W];

    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush aborts a fetch and beats a same-cycle completion
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        miss        = 1'b0;
        fill        = 1'b0;
        unique case (state_q)
            IDLE: begin
                miss = imemREN && !ihit;
                if (miss) begin
                    state_d     = FETCH;
                    miss_addr_d = imemaddr[ADDR_W-1:2];
                end
            end
            FETCH: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (!iwait) begin
                    state_d = IDLE;
                    fill    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        if (state_q == IDLE) begin
            ihit = imemREN && lookup_hit && !flush;
            if (ihit) begin
                imemload = data_q[req_idx];
            end
        end else begin
            iREN  = 1'b1;
            iaddr = {miss_addr_q, 2'b00};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            miss_addr_q <= '0;
        end else begin
            miss_addr_q <= miss_addr_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are qualified by valid_q
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (ihit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed self-checking bench for icache_fetch_ctrl (SETS=16): fills, hits, conflicts,
// flush, mid-fetch reset and statistics counters (expected values depend on ICACHE_STATS_EN).
module tb_icache_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic [31:0] imemload;
    logic        ihit;
    logic        flush = 1'b0;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload = '0;
    logic        iwait = 1'b1;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    icache_fetch_ctrl #(.SETS(16), .ADDR_W(32), .WORD_W(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .imemload   (imemload),
        .ihit       (ihit),
        .flush      (flush),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iload      (iload),
        .iwait      (iwait),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %08h expected %08h", tag, got, exp);
        end
    endtask

    // Full miss sequence: request, `waits` busy cycles, completion, then the retried hit.
    task automatic miss_fill(input logic [31:0] a, input logic [31:0] d, input int unsigned waits);
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1;
        #1;
        check("miss_ihit", 32'(ihit), 32'd0);
        check("miss_iren_idle", 32'(iREN), 32'd0);
        for (int unsigned i = 0; i < waits; i++) begin
            @(negedge CLK);
            #1;
            check("fetch_iren", 32'(iREN), 32'd1);
            check("fetch_iaddr", iaddr, {a[31:2], 2'b00});
        end
        @(negedge CLK);
        iwait = 1'b0; iload = d;
        #1;
        check("fill_iren", 32'(iREN), 32'd1);
        check("fill_iaddr", iaddr, {a[31:2], 2'b00});
        @(negedge CLK);
        iwait = 1'b1; iload = '0;
        #1;
        check("retry_ihit", 32'(ihit), 32'd1);
        check("retry_data", imemload, d);
        check("retry_iren", 32'(iREN), 32'd0);
    endtask

    task automatic expect_hit(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = a;
        #1;
        check("hit_ihit", 32'(ihit), 32'd1);
        check("hit_data", imemload, d);
        check("hit_iren", 32'(iREN), 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_iren", 32'(iREN), 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        check("rst_ihit", 32'(ihit), 32'd0);
        check("rst_imemload", imemload, 32'd0);
        check("rst_hitcnt", hit_count, 32'd0);
        check("rst_misscnt", miss_count, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Cold miss: 3 busy cycles + completion = 4 cycles of iREN, then the hit
        miss_fill(32'h0000_0040, 32'hDEAD_BEEF, 3);

        // Hits: same cycle, no memory request; byte offset ignored
        expect_hit(32'h0000_0040, 32'hDEAD_BEEF);
        expect_hit(32'h0000_0043, 32'hDEAD_BEEF);
        expect_hit(32'h0000_0040, 32'hDEAD_BEEF);
        expect_hit(32'h0000_0041, 32'hDEAD_BEEF);

        @(negedge CLK);
        imemREN = 1'b0;
        #1;
        check("idle_noreq_ihit", 32'(ihit), 32'd0);
`ifdef ICACHE_STATS_EN
        check("stats_hits", hit_count, 32'd5);
        check("stats_misses", miss_count, 32'd1);
`else
        check("stats_hits", hit_count, 32'd0);
        check("stats_misses", miss_count, 32'd0);
`endif

        // Neighbouring index is independent of idx 0
        miss_fill(32'h0000_0044, 32'h1111_0044, 1);
        expect_hit(32'h0000_0040, 32'hDEAD_BEEF);

        // Conflict: 0x80, 0x0 and 0x40 share idx 0, each fill evicts the previous tag
        miss_fill(32'h0000_0080, 32'h8080_8080, 1);
        miss_fill(32'h0000_0040, 32'h4040_4040, 0);
        miss_fill(32'h0000_0000, 32'h0000_AAAA, 0);
        miss_fill(32'h0000_0040, 32'h4040_5050, 0);
        expect_hit(32'h0000_0044, 32'h1111_0044);

        // Address change and request drop during FETCH: fill uses the latched address
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h0000_0148; iwait = 1'b1;
        @(negedge CLK);
        imemREN = 1'b0; imemaddr = 32'h0000_0200;
        #1;
        check("latched_iaddr", iaddr, 32'h0000_0148);
        @(negedge CLK);
        iwait = 1'b0; iload = 32'h0148_0148;
        @(negedge CLK);
        iwait = 1'b1; iload = '0;
        expect_hit(32'h0000_0148, 32'h0148_0148);

        // Flush pulse: the previously cached 0x40 misses afterwards
        @(negedge CLK);
        imemREN = 1'b0; flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0; imemREN = 1'b1; imemaddr = 32'h0000_0040;
        #1;
        check("flush_ihit", 32'(ihit), 32'd0);
        @(negedge CLK);
        #1;
        check("flush_refetch_iren", 32'(iREN), 32'd1);
        // Flush during FETCH aborts without fill
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0; imemREN = 1'b0;
        #1;
        check("abort_iren", 32'(iREN), 32'd0);
        check("abort_iaddr", iaddr, 32'd0);
        // Flush coinciding with completion: flush wins
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h0000_0040;
        @(negedge CLK);
        iwait = 1'b0; iload = 32'hBAD0_BAD0; flush = 1'b1;
        @(negedge CLK);
        iwait = 1'b1; iload = '0; flush = 1'b0;
        #1;
        check("flush_wins_ihit", 32'(ihit), 32'd0);
        check("flush_wins_iren", 32'(iREN), 32'd0);
        @(negedge CLK);
        imemREN = 1'b0;
        iwait = 1'b0; iload = 32'h600D_0040;
        #1;
        check("refill_iren", 32'(iREN), 32'd1);
        @(negedge CLK);
        iwait = 1'b1; iload = '0;
        expect_hit(32'h0000_0040, 32'h600D_0040);

        // Reset mid-fetch: iREN drops before any clock edge, no fill happens
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h0000_0084;
        @(negedge CLK);
        #1;
        check("prerst_iren", 32'(iREN), 32'd1);
        RST = 1'b1;
        #1;
        check("async_rst_iren", 32'(iREN), 32'd0);
        check("async_rst_iaddr", iaddr, 32'd0);
        iwait = 1'b0; iload = 32'hBAD1_BAD1;
        @(negedge CLK);
        RST = 1'b0; iwait = 1'b1; iload = '0;
        imemaddr = 32'h0000_0084;
        #1;
        check("postrst_0x84_ihit", 32'(ihit), 32'd0);
        imemaddr = 32'h0000_0040;
        #1;
        check("postrst_0x40_ihit", 32'(ihit), 32'd0);
        check("postrst_hitcnt", hit_count, 32'd0);
        check("postrst_misscnt", miss_count, 32'd0);
        @(negedge CLK);
        #1;
        check("postrst_iren", 32'(iREN), 32'd1);
        check("postrst_iaddr", iaddr, 32'h0000_0040);

        imemREN = 1'b0;
        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected $finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
